// File: rtl/hybrid_imc_tile_scheduler.sv
// Multi-tile hybrid IMC/digital scheduler: DRAM load, mode decision, compute,
// DRAM store and precision adaptation per tile, with a compute watchdog.
module hybrid_imc_tile_scheduler #(
  parameter int unsigned ROWS        = 64,
  parameter int unsigned OPS_W       = 16,
  parameter int unsigned ACC_W       = 24,
  parameter int unsigned TILE_W      = 8,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned ADDR_STRIDE = 16,
  parameter int unsigned SNR_LO      = 40,
  parameter int unsigned SNR_HI      = 80,
  parameter int unsigned SPARS_HI    = 60,
  parameter int unsigned SPARS_MID   = 30,
  parameter int unsigned RECOVER_CNT = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [TILE_W-1:0] num_tiles,
  output logic              done,
  output logic              busy,
  output logic              error_timeout,
  output logic              tile_start,
  input  logic              tile_done,
  output logic [TILE_W-1:0] tile_index,
  output logic              imc_mode,
  output logic [ROWS-1:0]   row_mask,
  input  logic [OPS_W-1:0]  zero_ops_skipped,
  input  logic [OPS_W-1:0]  ops_executed,
  input  logic [OPS_W-1:0]  energy_savings,
  input  logic [7:0]        computation_snr,
  output logic              dram_cmd_valid,
  input  logic              dram_cmd_ready,
  output logic [1:0]        dram_cmd_type,
  output logic [ADDR_W-1:0] dram_cmd_addr,
  output logic [1:0]        precision_mode,
  output logic              adaptive_en,
  output logic [ACC_W-1:0]  total_energy_saved,
  output logic [6:0]        sparsity_pct,
  output logic              snr_low
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam int unsigned NUM_W = ACC_W + 8;
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC + 2);
  localparam int unsigned GC_W  = $clog2(RECOVER_CNT + 2);
  localparam logic [1:0]  CMD_READ  = 2'b00;
  localparam logic [1:0]  CMD_WRITE = 2'b01;
  localparam logic [ROWS-1:0] HALF_MASK = {{(ROWS/2){1'b0}}, {(ROWS/2){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ANALYZE, S_COMPUTE, S_STORE, S_ADAPT, S_DONE, S_ERROR
  } state_e;

  state_e state_q, state_d;

  logic              done_q, done_d, busy_q, busy_d, err_q, err_d;
  logic              tstart_q, tstart_d, imc_q, imc_d;
  logic [ROWS-1:0]   mask_q, mask_d;
  logic [TILE_W-1:0] tiles_q, tiles_d, tidx_q, tidx_d;
  logic              valid_q, valid_d;
  logic [1:0]        type_q, type_d, prec_q, prec_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              adapt_q, adapt_d, snr_low_q, snr_low_d;
  logic [ACC_W-1:0]  skip_q, skip_d, exec_q, exec_d, energy_q, energy_d;
  logic [6:0]        spars_q, spars_d;
  logic [7:0]        avg_q, avg_d, last_snr_q, last_snr_d;
  logic [GC_W-1:0]   good_q, good_d;
  logic [WD_W-1:0]   wd_q, wd_d;

  logic [ACC_W-1:0]  skip_sum, exec_sum, energy_sum;
  logic [NUM_W-1:0]  num_w, den_w, quot_w;
  logic [7:0]        avg_new;
  logic [GC_W-1:0]   good_inc;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [OPS_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    return s[SUM_W-1] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input logic [TILE_W-1:0] t);
    return ADDR_W'(32'(t) * ADDR_STRIDE);
  endfunction

  // Per-tile result arithmetic: saturating sums, new sparsity ratio, SNR average
  assign skip_sum   = sat_add(skip_q, zero_ops_skipped);
  assign exec_sum   = sat_add(exec_q, ops_executed);
  assign energy_sum = sat_add(energy_q, energy_savings);
  assign num_w      = NUM_W'(skip_sum) * NUM_W'(100);
  assign den_w      = NUM_W'(skip_sum) + NUM_W'(exec_sum);
  assign quot_w     = (den_w == '0) ? '0 : num_w / den_w;
  assign avg_new    = 8'((9'(avg_q) + 9'(computation_snr)) >> 1);
  assign good_inc   = GC_W'(good_q + GC_W'(1));

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    done_d     = done_q;
    err_d      = err_q;
    tstart_d   = 1'b0;
    imc_d      = imc_q;
    mask_d     = mask_q;
    tiles_d    = tiles_q;
    tidx_d     = tidx_q;
    valid_d    = valid_q;
    type_d     = type_q;
    addr_d     = addr_q;
    prec_d     = prec_q;
    adapt_d    = adapt_q;
    snr_low_d  = snr_low_q;
    skip_d     = skip_q;
    exec_d     = exec_q;
    energy_d   = energy_q;
    spars_d    = spars_q;
    avg_d      = avg_q;
    last_snr_d = last_snr_q;
    good_d     = good_q;
    wd_d       = '0;

    case (state_q)
      S_IDLE: begin
        tidx_d   = '0;
        skip_d   = '0;
        exec_d   = '0;
        energy_d = '0;
        spars_d  = '0;
        avg_d    = 8'd100;
        if (start) begin
          tiles_d = num_tiles;
          if (num_tiles == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_LOAD;
            valid_d = 1'b1;
            type_d  = CMD_READ;
            addr_d  = addr_of('0);
          end
        end
      end
      S_LOAD: begin
        if (dram_cmd_ready) begin
          valid_d  = 1'b0;
          state_d  = S_ANALYZE;
          tstart_d = 1'b1;
          if (adapt_q && spars_q > 7'(SPARS_HI) && avg_q > 8'(SNR_LO)) begin
            imc_d  = 1'b1;
            mask_d = {ROWS{1'b1}};
          end else if (adapt_q && spars_q > 7'(SPARS_MID) && avg_q > 8'(SNR_HI)) begin
            imc_d  = 1'b1;
            mask_d = HALF_MASK;
          end else begin
            imc_d  = 1'b0;
            mask_d = '0;
          end
        end
      end
      S_ANALYZE: state_d = S_COMPUTE;
      S_COMPUTE: begin
        if (tile_done) begin
          skip_d     = skip_sum;
          exec_d     = exec_sum;
          if (imc_q) energy_d = energy_sum;
          spars_d    = 7'(quot_w);
          avg_d      = avg_new;
          last_snr_d = computation_snr;
          snr_low_d  = (computation_snr < 8'(SNR_LO));
          state_d    = S_STORE;
          valid_d    = 1'b1;
          type_d     = CMD_WRITE;
        end else if (TIMEOUT_CYC != 0 && wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = S_ERROR;
        end else begin
          wd_d = WD_W'(wd_q + WD_W'(1));
        end
      end
      S_STORE: begin
        if (dram_cmd_ready) begin
          valid_d = 1'b0;
          state_d = S_ADAPT;
        end
      end
      S_ADAPT: begin
        if (snr_low_q) begin
          if (prec_q == 2'd0) adapt_d = 1'b0;
          else                prec_d  = prec_q - 2'd1;
          good_d = '0;
        end else if (last_snr_q >= 8'(SNR_HI)) begin
          if (good_inc >= GC_W'(RECOVER_CNT)) begin
            prec_d  = (prec_q == 2'd3) ? 2'd3 : prec_q + 2'd1;
            adapt_d = 1'b1;
            good_d  = '0;
          end else begin
            good_d = good_inc;
          end
        end else begin
          good_d = '0;
        end
        if (tidx_q == TILE_W'(tiles_q - TILE_W'(1))) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          tidx_d  = TILE_W'(tidx_q + TILE_W'(1));
          state_d = S_LOAD;
          valid_d = 1'b1;
          type_d  = CMD_READ;
          addr_d  = addr_of(TILE_W'(tidx_q + TILE_W'(1)));
        end
      end
      S_DONE: begin
        if (!start) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_ERROR: begin
        if (!start) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Registered outputs and datapath state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      tstart_q   <= 1'b0;
      imc_q      <= 1'b0;
      mask_q     <= '0;
      tiles_q    <= '0;
      tidx_q     <= '0;
      valid_q    <= 1'b0;
      type_q     <= CMD_READ;
      addr_q     <= '0;
      prec_q     <= 2'b10;
      adapt_q    <= 1'b1;
      snr_low_q  <= 1'b0;
      skip_q     <= '0;
      exec_q     <= '0;
      energy_q   <= '0;
      spars_q    <= '0;
      avg_q      <= 8'd100;
      last_snr_q <= '0;
      good_q     <= '0;
      wd_q       <= '0;
    end else begin
      done_q     <= done_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      tstart_q   <= tstart_d;
      imc_q      <= imc_d;
      mask_q     <= mask_d;
      tiles_q    <= tiles_d;
      tidx_q     <= tidx_d;
      valid_q    <= valid_d;
      type_q     <= type_d;
      addr_q     <= addr_d;
      prec_q     <= prec_d;
      adapt_q    <= adapt_d;
      snr_low_q  <= snr_low_d;
      skip_q     <= skip_d;
      exec_q     <= exec_d;
      energy_q   <= energy_d;
      spars_q    <= spars_d;
      avg_q      <= avg_d;
      last_snr_q <= last_snr_d;
      good_q     <= good_d;
      wd_q       <= wd_d;
    end
  end

  assign done               = done_q;
  assign busy               = busy_q;
  assign error_timeout      = err_q;
  assign tile_start         = tstart_q;
  assign tile_index         = tidx_q;
  assign imc_mode           = imc_q;
  assign row_mask           = mask_q;
  assign dram_cmd_valid     = valid_q;
  assign dram_cmd_type      = type_q;
  assign dram_cmd_addr      = addr_q;
  assign precision_mode     = prec_q;
  assign adaptive_en        = adapt_q;
  assign total_energy_saved = energy_q;
  assign sparsity_pct       = spars_q;
  assign snr_low            = snr_low_q;

endmodule

// File: tb/tb_hybrid_imc_tile_scheduler.sv
// Directed self-checking bench for hybrid_imc_tile_scheduler (watchdog set to 8).
module tb_hybrid_imc_tile_scheduler;

  logic        clk, rst_n, start, tile_done, dram_cmd_ready;
  logic [7:0]  num_tiles, tile_index, computation_snr;
  logic        done, busy, error_timeout, tile_start, imc_mode;
  logic [63:0] row_mask;
  logic [15:0] zero_ops_skipped, ops_executed, energy_savings, dram_cmd_addr;
  logic        dram_cmd_valid, adaptive_en, snr_low;
  logic [1:0]  dram_cmd_type, precision_mode;
  logic [23:0] total_energy_saved;
  logic [6:0]  sparsity_pct;

  hybrid_imc_tile_scheduler #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_tiles(num_tiles),
    .done(done), .busy(busy), .error_timeout(error_timeout),
    .tile_start(tile_start), .tile_done(tile_done), .tile_index(tile_index),
    .imc_mode(imc_mode), .row_mask(row_mask),
    .zero_ops_skipped(zero_ops_skipped), .ops_executed(ops_executed),
    .energy_savings(energy_savings), .computation_snr(computation_snr),
    .dram_cmd_valid(dram_cmd_valid), .dram_cmd_ready(dram_cmd_ready),
    .dram_cmd_type(dram_cmd_type), .dram_cmd_addr(dram_cmd_addr),
    .precision_mode(precision_mode), .adaptive_en(adaptive_en),
    .total_energy_saved(total_energy_saved), .sparsity_pct(sparsity_pct),
    .snr_low(snr_low)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [17:0] xfer_q[$];

  // Record every accepted DRAM command as {type, addr}
  always @(posedge clk) begin
    if (dram_cmd_valid && dram_cmd_ready) xfer_q.push_back({dram_cmd_type, dram_cmd_addr});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; tile_done = 1'b0; num_tiles = '0;
    dram_cmd_ready = 1'b0; zero_ops_skipped = '0; ops_executed = '0;
    energy_savings = '0; computation_snr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_tile(input int idx, input int skip, input int exec_ops, input int en,
                          input int snr, input logic exp_imc, input logic [63:0] exp_mask);
    int n = 0;
    while (!tile_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("tile%0d_start", idx), tile_start, 1);
    chk($sformatf("tile%0d_index", idx), tile_index, idx);
    chk($sformatf("tile%0d_imc", idx), imc_mode, exp_imc);
    chk($sformatf("tile%0d_mask", idx), row_mask, exp_mask);
    @(negedge clk);
    @(negedge clk);
    tile_done = 1'b1;
    zero_ops_skipped = 16'(skip); ops_executed = 16'(exec_ops);
    energy_savings = 16'(en); computation_snr = 8'(snr);
    @(negedge clk);
    tile_done = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", done, 1);
  endtask

  initial begin
    logic [63:0] full, half;
    logic [17:0] ex;
    int base, n;
    full = '1;
    half = 64'h0000_0000_FFFF_FFFF;

    do_reset();
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_prec", precision_mode, 2);
    chk("rst_adapt", adaptive_en, 1);
    chk("rst_valid", dram_cmd_valid, 0);
    chk("rst_energy", total_energy_saved, 0);
    chk("rst_err", error_timeout, 0);

    // Three-tile job with ready always high; num_tiles changes mid-job are ignored
    base = xfer_q.size();
    num_tiles = 8'd3; dram_cmd_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    num_tiles = 8'd1;
    chk("t1_busy", busy, 1);
    run_tile(0, 80, 20, 5, 90, 1'b0, 64'd0);
    run_tile(1, 80, 20, 7, 90, 1'b1, full);
    run_tile(2, 80, 20, 9, 90, 1'b1, full);
    wait_done();
    chk("t1_energy", total_energy_saved, 16);
    chk("t1_spars", sparsity_pct, 80);
    chk("t1_prec", precision_mode, 2);
    chk("t1_busy_done", busy, 1);
    chk("t1_nxfer", xfer_q.size() - base, 6);
    for (int i = 0; i < 6; i++) begin
      ex = {((i % 2) == 1) ? 2'b01 : 2'b00, 16'((i / 2) * 16)};
      chk($sformatf("t1_xfer%0d", i), xfer_q[base + i], ex);
    end
    start = 1'b0;
    @(negedge clk);
    chk("t1_done_clr", done, 0);
    chk("t1_idle", busy, 0);

    // Back-pressure in LOAD: command held stable while ready is low
    do_reset();
    base = xfer_q.size();
    num_tiles = 8'd1; start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("t2_valid%0d", k), dram_cmd_valid, 1);
      chk($sformatf("t2_addr%0d", k), dram_cmd_addr, 0);
      chk($sformatf("t2_type%0d", k), dram_cmd_type, 0);
      chk($sformatf("t2_tstart%0d", k), tile_start, 0);
    end
    dram_cmd_ready = 1'b1;
    @(negedge clk);
    chk("t2_valid_drop", dram_cmd_valid, 0);
    chk("t2_analyze", tile_start, 1);
    chk("t2_one_read", xfer_q.size() - base, 1);
    run_tile(0, 10, 30, 4, 90, 1'b0, 64'd0);
    wait_done();
    chk("t2_spars", sparsity_pct, 25);
    chk("t2_energy", total_energy_saved, 0);
    chk("t2_nxfer", xfer_q.size() - base, 2);
    ex = {2'b01, 16'd0};
    chk("t2_write", xfer_q[base + 1], ex);
    start = 1'b0;
    @(negedge clk);

    // Low SNR drops precision to 0, then disables adaptation
    do_reset();
    num_tiles = 8'd3; dram_cmd_ready = 1'b1; start = 1'b1;
    run_tile(0, 80, 20, 3, 30, 1'b0, 64'd0);
    run_tile(1, 80, 20, 3, 30, 1'b1, full);
    run_tile(2, 80, 20, 3, 30, 1'b1, full);
    wait_done();
    chk("t3_prec", precision_mode, 0);
    chk("t3_adapt", adaptive_en, 0);
    chk("t3_snrlow", snr_low, 1);
    chk("t3_energy", total_energy_saved, 6);
    start = 1'b0;
    @(negedge clk);

    // Recovery: four high-SNR tiles restore one precision step and adaptation
    num_tiles = 8'd6; start = 1'b1;
    run_tile(0, 80, 20, 2, 85, 1'b0, 64'd0);
    run_tile(1, 80, 20, 2, 85, 1'b0, 64'd0);
    run_tile(2, 80, 20, 2, 85, 1'b0, 64'd0);
    run_tile(3, 80, 20, 2, 85, 1'b0, 64'd0);
    chk("t4_prec_before", precision_mode, 0);
    run_tile(4, 80, 20, 2, 85, 1'b1, full);
    chk("t4_prec_after", precision_mode, 1);
    chk("t4_adapt", adaptive_en, 1);
    run_tile(5, 80, 20, 2, 85, 1'b1, full);
    wait_done();
    chk("t4_energy", total_energy_saved, 4);
    chk("t4_prec_end", precision_mode, 1);
    start = 1'b0;
    @(negedge clk);

    // Sparsity exactly at the high threshold selects the half mask
    do_reset();
    num_tiles = 8'd2; dram_cmd_ready = 1'b1; start = 1'b1;
    run_tile(0, 60, 40, 1, 90, 1'b0, 64'd0);
    run_tile(1, 60, 40, 1, 90, 1'b1, half);
    wait_done();
    chk("t5_energy", total_energy_saved, 1);
    chk("t5_spars", sparsity_pct, 60);
    start = 1'b0;
    @(negedge clk);

    // Watchdog: tile_done never arrives
    do_reset();
    base = xfer_q.size();
    num_tiles = 8'd2; dram_cmd_ready = 1'b1; start = 1'b1;
    n = 0;
    while (!tile_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_tstart", tile_start, 1);
    repeat (8) @(negedge clk);
    chk("t6_err_early", error_timeout, 0);
    @(negedge clk);
    chk("t6_err", error_timeout, 1);
    chk("t6_busy", busy, 1);
    repeat (3) @(negedge clk);
    chk("t6_valid", dram_cmd_valid, 0);
    chk("t6_no_write", xfer_q.size() - base, 1);
    start = 1'b0;
    @(negedge clk);
    chk("t6_err_clr", error_timeout, 0);
    chk("t6_idle", busy, 0);

    // Zero-tile job completes immediately with no activity
    do_reset();
    base = xfer_q.size();
    num_tiles = 8'd0; dram_cmd_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("t7_done", done, 1);
    chk("t7_tstart", tile_start, 0);
    chk("t7_valid", dram_cmd_valid, 0);
    @(negedge clk);
    chk("t7_nxfer", xfer_q.size() - base, 0);
    start = 1'b0;
    @(negedge clk);
    chk("t7_done_clr", done, 0);

    // Asynchronous reset in the middle of COMPUTE
    do_reset();
    num_tiles = 8'd2; dram_cmd_ready = 1'b1; start = 1'b1;
    n = 0;
    while (!tile_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("t8_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t8_busy", busy, 0);
    chk("t8_index", tile_index, 0);
    chk("t8_prec", precision_mode, 2);
    chk("t8_adapt", adaptive_en, 1);
    chk("t8_valid", dram_cmd_valid, 0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    base = xfer_q.size();
    repeat (4) @(negedge clk);
    chk("t8_nxfer", xfer_q.size() - base, 0);
    chk("t8_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hybrid_imc_tile_scheduler.md
Name: hybrid_imc_tile_scheduler

Overview:
- Parametrised multi-tile successor to the hybrid IMC/digital controller.
- Sequences a programmable number of tiles through DRAM load, mode decision, compute, DRAM store and adaptation.
- Adds a valid/ready DRAM command handshake, saturating statistics, precision recovery with hysteresis, and a compute watchdog.
- Sits between the top-level start/done control, the tile compute engine and the DRAM command port.

Parameters:
ROWS, 64, row_mask width (even, >=2)
OPS_W, 16, width of per-tile op/energy counts
ACC_W, 24, width of cumulative accumulators (>= OPS_W)
TILE_W, 8, width of num_tiles and tile_index
ADDR_W, 16, DRAM address width
ADDR_STRIDE, 16, address increment per tile
SNR_LO, 40, low SNR threshold
SNR_HI, 80, high SNR threshold
SPARS_HI, 60, aggressive-IMC sparsity threshold (percent)
SPARS_MID, 30, moderate-IMC sparsity threshold (percent)
RECOVER_CNT, 4, consecutive high-SNR tiles needed to raise precision
TIMEOUT_CYC, 1024, compute watchdog limit; 0 disables

Ports:
clk  in  1  clock
rst_n  in  1  reset
start  in  1  level start request
num_tiles  in  TILE_W  tiles per job, sampled on start
done  out  1  job complete, held until start falls
busy  out  1  high whenever state != IDLE
error_timeout  out  1  watchdog fired, held until start falls
tile_start  out  1  one-cycle pulse launching a tile
tile_done  in  1  tile finished, results valid this cycle
tile_index  out  TILE_W  current tile number
imc_mode  out  1  1 = IMC, 0 = digital
row_mask  out  ROWS  active rows
zero_ops_skipped  in  OPS_W  tile skipped ops
ops_executed  in  OPS_W  tile executed ops
energy_savings  in  OPS_W  tile IMC energy saving
computation_snr  in  8  tile SNR
dram_cmd_valid  out  1  command valid
dram_cmd_ready  in  1  command accepted
dram_cmd_type  out  2  00 = READ, 01 = WRITE
dram_cmd_addr  out  ADDR_W  tile_index*ADDR_STRIDE, truncated
precision_mode  out  2  current precision
adaptive_en  out  1  adaptive IMC enabled
total_energy_saved  out  ACC_W  saturating job energy sum
sparsity_pct  out  7  cumulative sparsity, 0..100
snr_low  out  1  last tile SNR < SNR_LO

Behaviour:
- Clock and reset: single clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values:
  - All outputs 0, except precision_mode=2'b10 and adaptive_en=1.
  - Internal avg_snr=100, good_cnt=0.
  - Reset mid-job aborts immediately, with no further commands issued.
- States: IDLE, LOAD, ANALYZE, COMPUTE, STORE, ADAPT, DONE, ERROR.
- IDLE:
  - Clear tile_index, accumulators, total_energy_saved, sparsity_pct; avg_snr=100.
  - On start=1: latch num_tiles.
  - If latched value is 0, go to DONE; otherwise go to LOAD with dram_cmd_valid=1, type READ, addr for tile_index, all asserted the next cycle.
- LOAD / STORE handshake:
  - valid, type and addr hold stable until the cycle with valid&&ready.
  - valid drops the following cycle.
  - LOAD goes to ANALYZE; STORE goes to ADAPT.
  - STORE issues WRITE to the same addr.
- ANALYZE (one cycle):
  - Pulse tile_start, then go to COMPUTE.
  - With adaptive_en, using registered sparsity_pct and avg_snr:
    - sparsity_pct>SPARS_HI && avg_snr>SNR_LO: imc_mode=1, row_mask all ones.
    - else sparsity_pct>SPARS_MID && avg_snr>SNR_HI: imc_mode=1, lower ROWS/2 bits set.
    - else: imc_mode=0, row_mask=0.
  - With !adaptive_en: always digital.
- COMPUTE:
  - tile_done is honoured only in this state.
  - On tile_done:
    - Add skipped/executed into ACC_W saturating sums, and energy_savings into total_energy_saved only if imc_mode.
    - avg_snr=(avg_snr+computation_snr)>>1 using a 9-bit intermediate.
    - snr_low=(computation_snr<SNR_LO).
    - Go to STORE with the WRITE command asserted next cycle.
  - sparsity_pct is recomputed from the new sums: skipped*100/(skipped+executed); 0 when the denominator is 0; visible from STORE onward.
  - Watchdog counts cycles in COMPUTE; reaching TIMEOUT_CYC without tile_done sets error_timeout and goes to ERROR.
- ADAPT (one cycle), precision update:
  - If snr_low: decrement precision_mode; if already 0, clear adaptive_en. good_cnt=0.
  - Else if last SNR>=SNR_HI: good_cnt++. On reaching RECOVER_CNT, increment precision_mode (cap 3), set adaptive_en=1, good_cnt=0.
  - Otherwise good_cnt=0.
- ADAPT, tile advance:
  - If tile_index==latched_num_tiles-1, go to DONE.
  - Otherwise increment tile_index and go to LOAD.
- DONE: done=1, busy=1. When start=0: done=0, go to IDLE.
- ERROR: busy=1, no commands issued. When start=0: clear error_timeout, go to IDLE.
- start is ignored outside IDLE; num_tiles changes mid-job are ignored.

Test Plan:
- num_tiles=3, ready always 1, tile_done 2 cycles after tile_start, skipped=80/executed=20, snr=90 -> tile 0 digital (sparsity_pct=0), tiles 1-2 imc_mode=1 with full mask; READ/WRITE addrs 0, 16, 32; done=1 after tile 2; total_energy_saved = sum of tiles 1-2.
- dram_cmd_ready held low 5 cycles in LOAD -> valid/addr stable all 5 cycles, exactly one transfer, ANALYZE entered the cycle after ready.
- snr=30 on every tile from reset (precision 2) -> precision 1, then 0, then adaptive_en=0; later tiles digital regardless of sparsity.
- After precision drop, 4 consecutive tiles with snr=85 -> precision_mode increments by 1, adaptive_en=1.
- TIMEOUT_CYC=8 and tile_done never asserted -> error_timeout=1 after 8 COMPUTE cycles, no WRITE issued; start low -> IDLE, busy=0.
- num_tiles=0 -> no tile_start and no DRAM command, done=1 one cycle after start. rst_n asserted mid-COMPUTE -> all outputs return to reset values asynchronously.
